// File: rtl/conv_pe_ctrl_if.sv
// rtl/conv_pe_ctrl_if.sv - PE sequencer bus: weight memory, pixel source, PE control and output beats
// master = controller side, slave = buffers/PE side.
interface conv_pe_ctrl_if #(
  parameter int WIDTH = 9
);
  logic                   w_rd_en;
  logic [3:0]             w_rd_addr;
  logic [WIDTH-1:0]       w_rd_data;
  logic                   pe_weight_we;
  logic [3:0]             pe_weight_idx;
  logic [WIDTH-1:0]       pe_weight;
  logic                   src_valid;
  logic [WIDTH-1:0]       src_data;
  logic                   src_ready;
  logic                   pe_sr_shift;
  logic [WIDTH-1:0]       pe_data;
  logic                   pe_cu_en;
  logic [2*WIDTH-1:0]     pe_result;
  logic                   out_valid;
  logic [2*WIDTH-1:0]     out_data;

  modport master (
    output w_rd_en, w_rd_addr, pe_weight_we, pe_weight_idx, pe_weight,
           src_ready, pe_sr_shift, pe_data, pe_cu_en, out_valid, out_data,
    input  w_rd_data, src_valid, src_data, pe_result
  );

  modport slave (
    input  w_rd_en, w_rd_addr, pe_weight_we, pe_weight_idx, pe_weight,
           src_ready, pe_sr_shift, pe_data, pe_cu_en, out_valid, out_data,
    output w_rd_data, src_valid, src_data, pe_result
  );
endinterface

// File: rtl/conv_pe_ctrl.sv
// rtl/conv_pe_ctrl.sv - frame sequencer for one 3x3 convolution PE
// Loads kernel weights, streams pixels into the PE, gates the conv unit and tags results.
module conv_pe_ctrl #(
  parameter int WIDTH     = 9,
  parameter int TAPS      = 9,
  parameter int FRAME_LEN = 96,
  parameter int CU_LAT    = 2
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic           i_start,
  output logic           o_busy,
  output logic           o_done,
  conv_pe_ctrl_if.master bus
);
  localparam int CW  = $clog2(FRAME_LEN + 1);
  localparam int WCW = $clog2(TAPS + 1);
  localparam logic [CW-1:0]  BEAT_TAPS = CW'(TAPS);
  localparam logic [CW-1:0]  BEAT_LAST = CW'(FRAME_LEN);
  localparam logic [WCW-1:0] W_LAST    = WCW'(TAPS);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_W, S_FILL, S_RUN, S_DRAIN, S_DONE
  } state_t;

  state_t               r_state, w_next;
  logic [WCW-1:0]       r_wcnt;
  logic [CW-1:0]        r_beat;
  logic [CW-1:0]        w_beat_inc;
  logic                 r_cu_en;
  logic                 r_out_valid;
  logic [2*WIDTH-1:0]   r_out_data;
  logic [WIDTH-1:0]     r_pe_data;
  logic                 w_src_ready;
  logic                 w_accept;
  logic                 w_load;
  logic                 w_rd_go;
  logic                 w_wr_go;
  logic                 w_tap;
  logic                 w_pipe_busy;

  assign w_accept   = bus.src_valid & w_src_ready;
  assign w_beat_inc = r_beat + CW'(1);

  always_comb begin
    w_next      = r_state;
    w_src_ready = 1'b0;
    o_busy      = 1'b1;
    o_done      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        o_busy = 1'b0;
        if (i_start) w_next = S_LOAD_W;
      end
      S_LOAD_W: begin
        if (r_wcnt == W_LAST) w_next = S_FILL;
      end
      S_FILL: begin
        w_src_ready = 1'b1;
        if (w_accept && (w_beat_inc == BEAT_TAPS))
          w_next = (FRAME_LEN == TAPS) ? S_DRAIN : S_RUN;
      end
      S_RUN: begin
        w_src_ready = 1'b1;
        if (w_accept && (w_beat_inc == BEAT_LAST)) w_next = S_DRAIN;
      end
      S_DRAIN: begin
        // Last out_valid may be issuing this cycle; nothing left behind it.
        if (!r_cu_en && !w_pipe_busy) w_next = S_DONE;
      end
      S_DONE: begin
        o_done = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Read address k is issued in load cycle k; its data lands one cycle later.
  assign w_load  = (r_state == S_LOAD_W);
  assign w_rd_go = w_load && (r_wcnt != W_LAST);
  assign w_wr_go = w_load && (r_wcnt != '0);

  assign bus.w_rd_en       = w_rd_go;
  assign bus.w_rd_addr     = w_rd_go ? 4'(r_wcnt) : 4'd0;
  assign bus.pe_weight_we  = w_wr_go;
  assign bus.pe_weight_idx = w_wr_go ? 4'(r_wcnt - WCW'(1)) : 4'd0;
  assign bus.pe_weight     = w_wr_go ? bus.w_rd_data : '0;
  assign bus.src_ready     = w_src_ready;
  assign bus.pe_sr_shift   = w_accept;
  assign bus.pe_data       = w_accept ? bus.src_data : r_pe_data;
  assign bus.pe_cu_en      = r_cu_en;
  assign bus.out_valid     = r_out_valid;
  assign bus.out_data      = r_out_data;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_wcnt      <= '0;
      r_beat      <= '0;
      r_cu_en     <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_pe_data   <= '0;
    end else begin
      r_state     <= w_next;
      r_wcnt      <= w_load ? r_wcnt + WCW'(1) : '0;
      r_cu_en     <= w_accept && (w_beat_inc >= BEAT_TAPS);
      r_out_valid <= w_tap;
      if (w_tap) r_out_data <= bus.pe_result;
      if (r_state == S_IDLE) begin
        r_beat <= '0;
      end else if (w_accept) begin
        r_beat    <= w_beat_inc;
        r_pe_data <= bus.src_data;
      end
    end
  end

  // w_tap is pe_cu_en delayed CU_LAT-1 cycles; out_valid adds the final register stage.
  generate
    if (CU_LAT == 1) begin : g_nopipe
      assign w_tap       = r_cu_en;
      assign w_pipe_busy = 1'b0;
    end else begin : g_pipe
      logic [CU_LAT-2:0] r_vpipe;
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          r_vpipe <= '0;
        end else begin
          r_vpipe[0] <= r_cu_en;
          for (int i = 1; i < CU_LAT - 1; i++) r_vpipe[i] <= r_vpipe[i-1];
        end
      end
      assign w_tap       = r_vpipe[CU_LAT-2];
      assign w_pipe_busy = |r_vpipe;
    end
  endgenerate
endmodule

// File: tb/tb_conv_pe_ctrl.sv
// tb/tb_conv_pe_ctrl.sv - scoreboard bench for conv_pe_ctrl with weight memory and PE models
module tb_conv_pe_ctrl;
  localparam int W      = 9;
  localparam int TAPS   = 9;
  localparam int FL     = 96;
  localparam int CU_LAT = 2;

  typedef struct {
    int cyc;
    int val;
    int aux;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n;
  logic start_a, busy_a, done_a;
  logic start_b, busy_b, done_b;

  conv_pe_ctrl_if #(.WIDTH(W)) bus_a ();
  conv_pe_ctrl_if #(.WIDTH(W)) bus_b ();

  conv_pe_ctrl #(.WIDTH(W), .TAPS(TAPS), .FRAME_LEN(FL), .CU_LAT(CU_LAT)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start_a),
    .o_busy(busy_a), .o_done(done_a), .bus(bus_a)
  );

  conv_pe_ctrl #(.WIDTH(W), .TAPS(TAPS), .FRAME_LEN(TAPS), .CU_LAT(CU_LAT)) u_dut_small (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start_b),
    .o_busy(busy_b), .o_done(done_b), .bus(bus_b)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  function automatic void chk(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  always @(posedge clk) cyc++;

  // Weight memory: registered read port.
  logic [W-1:0] wmem [0:15];
  always @(posedge clk) if (bus_a.w_rd_en) bus_a.w_rd_data <= wmem[bus_a.w_rd_addr];

  // PE: weight slots, shift register (sr[0] newest), conv result presented after pe_cu_en.
  logic [W-1:0] pe_w [0:TAPS-1];
  logic [W-1:0] sr   [0:TAPS-1];
  function automatic logic [2*W-1:0] pe_dot();
    logic [2*W-1:0] s;
    s = '0;
    for (int k = 0; k < TAPS; k++) s = s + pe_w[k] * sr[k];
    return s;
  endfunction
  always @(posedge clk) begin
    if (bus_a.pe_weight_we) pe_w[bus_a.pe_weight_idx] <= bus_a.pe_weight;
    if (bus_a.pe_sr_shift) begin
      for (int k = TAPS - 1; k > 0; k--) sr[k] <= sr[k-1];
      sr[0] <= bus_a.pe_data;
    end
    if (bus_a.pe_cu_en) bus_a.pe_result <= pe_dot();
  end

  // Reference: window ending at 1-based beat n, newest pixel times weight 0.
  logic [W-1:0] frame_pix [0:127];
  function automatic logic [2*W-1:0] ref_dot(input int n);
    longint s;
    s = 0;
    for (int k = 0; k < TAPS; k++) s += longint'(wmem[k]) * longint'(frame_pix[n-1-k]);
    return (2*W)'(s);
  endfunction

  ev_t rd_q[$], we_q[$], cu_q[$], out_q[$];
  int  n_cu_a = 0, n_ov_a = 0, n_sh_a = 0, n_done_a = 0;
  ev_t m_e;

  always @(posedge clk) if (rst_n && bus_a.pe_sr_shift) n_sh_a++;

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus_a.w_rd_en) begin
        if (rd_q.size() == 0) chk("w_rd_unexpected", 1, 0);
        else begin
          m_e = rd_q.pop_front();
          chk("w_rd_cycle", cyc, m_e.cyc);
          chk("w_rd_addr", bus_a.w_rd_addr, m_e.val);
        end
      end
      if (bus_a.pe_weight_we) begin
        if (we_q.size() == 0) chk("pe_weight_we_unexpected", 1, 0);
        else begin
          m_e = we_q.pop_front();
          chk("pe_weight_we_cycle", cyc, m_e.cyc);
          chk("pe_weight_idx", bus_a.pe_weight_idx, m_e.val);
          chk("pe_weight", bus_a.pe_weight, m_e.aux);
        end
      end
      if (bus_a.pe_cu_en) begin
        n_cu_a++;
        if (cu_q.size() == 0) chk("pe_cu_en_unexpected", 1, 0);
        else begin
          m_e = cu_q.pop_front();
          chk("pe_cu_en_cycle", cyc, m_e.cyc);
        end
      end
      if (bus_a.out_valid) begin
        n_ov_a++;
        if (out_q.size() == 0) chk("out_valid_unexpected", 1, 0);
        else begin
          m_e = out_q.pop_front();
          chk("out_valid_cycle", cyc, m_e.cyc);
          chk("out_data", bus_a.out_data, m_e.aux);
        end
      end
      if (done_a) n_done_a++;
    end
  end

  int n_cu_b = 0, n_ov_b = 0, n_done_b = 0;
  int cu_cyc_b = 0, ov_cyc_b = 0, done_cyc_b = 0;
  logic [2*W-1:0] ov_data_b = '0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus_b.pe_cu_en)  begin n_cu_b++; cu_cyc_b = cyc; end
      if (bus_b.out_valid) begin n_ov_b++; ov_cyc_b = cyc; ov_data_b = bus_b.out_data; end
      if (done_b)          begin n_done_b++; done_cyc_b = cyc; end
    end
  end

  // mode 0: valid every cycle, 1: toggling, 2: random gaps.
  task automatic run_frame(input int mode, input bit ramp, input bit poke, input int abort_beat);
    int  c0, cl, b_cu, b_ov, b_sh, b_done, n;
    bit  tog, v, got;
    ev_t e;
    tog = 1'b1; n = 0; cl = 0; got = 1'b0;
    for (int k = 0; k < 16; k++) wmem[k] = ramp ? W'(k + 5) : W'($urandom);
    b_cu = n_cu_a; b_ov = n_ov_a; b_sh = n_sh_a; b_done = n_done_a;
    @(negedge clk);
    start_a = 1'b1;
    c0 = cyc;
    for (int k = 0; k < TAPS; k++) begin
      e.cyc = c0 + 1 + k; e.val = k; e.aux = 0;
      rd_q.push_back(e);
      e.cyc = c0 + 2 + k; e.aux = int'(wmem[k]);
      we_q.push_back(e);
    end
    @(negedge clk);
    start_a = 1'b0;
    repeat (9) @(negedge clk);
    chk("src_ready_in_load_w", bus_a.src_ready, 0);
    @(negedge clk);
    chk("busy_in_fill", busy_a, 1);
    while (n < FL) begin
      case (mode)
        0:       v = 1'b1;
        1:       begin v = tog; tog = ~tog; end
        default: v = ($urandom_range(0, 3) != 0);
      endcase
      if (abort_beat != 0 && n + 1 == abort_beat) begin
        #1;
        bus_a.src_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", busy_a, 0);
        chk("abort_src_ready", bus_a.src_ready, 0);
        chk("abort_pe_cu_en", bus_a.pe_cu_en, 0);
        chk("abort_out_valid", bus_a.out_valid, 0);
        chk("abort_out_data", bus_a.out_data, 0);
        chk("abort_pe_data", bus_a.pe_data, 0);
        cu_q.delete();
        out_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("abort_no_done", n_done_a, b_done);
        chk("abort_idle", busy_a, 0);
        return;
      end
      if (v) begin
        bus_a.src_valid = 1'b1;
        bus_a.src_data  = (mode == 0) ? W'(n + 1) : W'($urandom);
        frame_pix[n] = bus_a.src_data;
        n++;
        #1;
        chk("src_ready", bus_a.src_ready, 1);
        chk("pe_sr_shift", bus_a.pe_sr_shift, 1);
        chk("pe_data_pass", bus_a.pe_data, frame_pix[n-1]);
        if (n >= TAPS) begin
          e.cyc = cyc + 1; e.val = n; e.aux = 0;
          cu_q.push_back(e);
          e.cyc = cyc + 1 + CU_LAT; e.aux = int'(ref_dot(n));
          out_q.push_back(e);
        end
        if (poke && n == 50) start_a = 1'b1;
        if (n == FL) cl = cyc;
      end else begin
        bus_a.src_valid = 1'b0;
        bus_a.src_data  = W'($urandom);
        #1;
        chk("no_shift_when_invalid", bus_a.pe_sr_shift, 0);
        if (n > 0) chk("pe_data_hold", bus_a.pe_data, frame_pix[n-1]);
      end
      @(negedge clk);
      start_a = 1'b0;
    end
    bus_a.src_valid = 1'b0;
    if (poke) start_a = 1'b1;
    for (int t = 0; t < 60 && !got; t++) begin
      if (done_a) got = 1'b1;
      else begin
        @(negedge clk);
        start_a = 1'b0;
      end
    end
    chk("done_seen", got, 1);
    if (got) chk("done_cycle", cyc, cl + 4);
    @(negedge clk);
    chk("idle_after_done_busy", busy_a, 0);
    chk("done_one_cycle", done_a, 0);
    repeat (3) @(negedge clk);
    chk("start_not_queued", busy_a, 0);
    chk("cu_en_count", n_cu_a - b_cu, FL - TAPS + 1);
    chk("out_valid_count", n_ov_a - b_ov, FL - TAPS + 1);
    chk("shift_count", n_sh_a - b_sh, FL);
    chk("done_count", n_done_a - b_done, 1);
    chk("pending_expectations", rd_q.size() + we_q.size() + cu_q.size() + out_q.size(), 0);
  endtask

  task automatic run_small();
    int c0, cl;
    bit got;
    logic [2*W-1:0] k_res;
    got = 1'b0;
    k_res = (2*W)'($urandom);
    bus_b.pe_result = k_res;
    @(negedge clk);
    start_b = 1'b1;
    c0 = cyc;
    @(negedge clk);
    start_b = 1'b0;
    repeat (10) @(negedge clk);
    for (int n = 0; n < TAPS; n++) begin
      bus_b.src_valid = 1'b1;
      bus_b.src_data  = W'($urandom);
      #1;
      chk("small_src_ready", bus_b.src_ready, 1);
      @(negedge clk);
    end
    bus_b.src_valid = 1'b0;
    cl = c0 + 11 + TAPS - 1;
    for (int t = 0; t < 40 && !got; t++) begin
      if (done_b) got = 1'b1;
      else @(negedge clk);
    end
    chk("small_done_seen", got, 1);
    @(negedge clk);
    chk("small_busy_after", busy_b, 0);
    chk("small_cu_en_count", n_cu_b, 1);
    chk("small_cu_en_cycle", cu_cyc_b, cl + 1);
    chk("small_out_valid_count", n_ov_b, 1);
    chk("small_out_valid_cycle", ov_cyc_b, cl + 1 + CU_LAT);
    chk("small_out_data", ov_data_b, k_res);
    chk("small_done_count", n_done_b, 1);
    chk("small_done_cycle", done_cyc_b, cl + 4);
  endtask

  initial begin
    rst_n = 1'b0;
    start_a = 1'b0; start_b = 1'b0;
    bus_a.src_valid = 1'b0; bus_a.src_data = '0; bus_a.pe_result = '0; bus_a.w_rd_data = '0;
    bus_b.src_valid = 1'b0; bus_b.src_data = '0; bus_b.pe_result = '0; bus_b.w_rd_data = '0;
    for (int k = 0; k < 16; k++) wmem[k] = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_w_rd_en", bus_a.w_rd_en, 0);
    chk("rst_w_rd_addr", bus_a.w_rd_addr, 0);
    chk("rst_pe_weight_we", bus_a.pe_weight_we, 0);
    chk("rst_src_ready", bus_a.src_ready, 0);
    chk("rst_pe_sr_shift", bus_a.pe_sr_shift, 0);
    chk("rst_pe_data", bus_a.pe_data, 0);
    chk("rst_pe_cu_en", bus_a.pe_cu_en, 0);
    chk("rst_out_valid", bus_a.out_valid, 0);
    chk("rst_out_data", bus_a.out_data, 0);
    chk("rst_small_busy", busy_b, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_frame(0, 1'b1, 1'b0, 0);
    run_frame(1, 1'b0, 1'b0, 0);
    run_frame(0, 1'b0, 1'b1, 0);
    run_frame(2, 1'b0, 1'b0, 0);
    run_frame(0, 1'b0, 1'b0, 40);
    run_frame(2, 1'b0, 1'b0, 0);
    run_small();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end
endmodule
